// File: rtl/led_strip_scheduler.sv
// Round-robin arbiter that shares one addressable-LED strip driver between N_REQ
// pattern sources, with finish-edge detection, a WAIT timeout and a post-frame latch gap.
module led_strip_scheduler #(
  parameter int N_REQ          = 4,
  parameter int LATCH_CYCLES   = 2500,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [24*N_REQ-1:0]    req_color,
  input  logic [7*N_REQ-1:0]     req_index,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic                   timeout_sticky,
  output logic                   busy,
  output logic                   led_start,
  output logic [23:0]            led_color,
  output logic [6:0]             led_start_index,
  input  logic                   led_finish
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int LA_W  = $clog2(LATCH_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] owner_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic [LA_W-1:0]  la_cnt_reg;
  logic             led_finish_d_reg;
  logic [N_REQ-1:0] done_reg;
  logic             err_reg;
  logic             sticky_reg;
  logic             led_start_reg;
  logic [23:0]      led_color_reg;
  logic [6:0]       led_index_reg;

  logic [23:0]      color_arr [N_REQ];
  logic [6:0]       index_arr [N_REQ];
  logic [PTR_W:0]   cand_sum  [N_REQ];
  logic [PTR_W-1:0] cand_idx  [N_REQ];
  logic [N_REQ-1:0] cand_req;
  logic [N_REQ-1:0] owner_onehot;
  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             finish_edge;
  logic             timeout_hit;
  logic             latch_last;

  // Candidate gi is the requester gi positions above the pointer, wrapped modulo N_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign color_arr[gi]    = req_color[24*gi +: 24];
      assign index_arr[gi]    = req_index[7*gi +: 7];
      assign cand_sum[gi]     = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
      assign cand_idx[gi]     = (cand_sum[gi] >= (PTR_W+1)'(N_REQ))
                                ? PTR_W'(cand_sum[gi] - (PTR_W+1)'(N_REQ))
                                : PTR_W'(cand_sum[gi]);
      assign cand_req[gi]     = req[cand_idx[gi]];
      assign owner_onehot[gi] = (owner_reg == PTR_W'(gi));
    end
  endgenerate

  // Scan downward so the nearest candidate to the pointer is the last one written.
  always_comb begin
    grant_found = |cand_req;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        grant_idx = cand_idx[k];
      end
    end
  end

  assign next_ptr    = (owner_reg == PTR_W'(N_REQ - 1)) ? '0 : owner_reg + PTR_W'(1);
  assign finish_edge = led_finish & ~led_finish_d_reg;
  assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign latch_last  = (la_cnt_reg == LA_W'(LATCH_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (grant_found) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (finish_edge || timeout_hit) state_next = ST_LATCH;
      ST_LATCH: if (latch_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      ptr_reg          <= '0;
      owner_reg        <= '0;
      to_cnt_reg       <= '0;
      la_cnt_reg       <= '0;
      led_finish_d_reg <= 1'b0;
      done_reg         <= '0;
      err_reg          <= 1'b0;
      sticky_reg       <= 1'b0;
      led_start_reg    <= 1'b0;
      led_color_reg    <= '0;
      led_index_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      led_finish_d_reg <= led_finish;
      done_reg         <= '0;
      err_reg          <= 1'b0;
      led_start_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_found) begin
            owner_reg     <= grant_idx;
            led_color_reg <= color_arr[grant_idx];
            led_index_reg <= index_arr[grant_idx];
            led_start_reg <= 1'b1;
          end
        end
        ST_ISSUE: begin
          to_cnt_reg <= '0;
        end
        ST_WAIT: begin
          // A finish edge takes priority over a coincident terminal count.
          if (finish_edge) begin
            done_reg   <= owner_onehot;
            la_cnt_reg <= '0;
            ptr_reg    <= next_ptr;
          end else if (timeout_hit) begin
            done_reg   <= owner_onehot;
            err_reg    <= 1'b1;
            sticky_reg <= 1'b1;
            la_cnt_reg <= '0;
            ptr_reg    <= next_ptr;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        ST_LATCH: begin
          if (!latch_last) begin
            la_cnt_reg <= la_cnt_reg + LA_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign done            = done_reg;
  assign err             = err_reg;
  assign timeout_sticky  = sticky_reg;
  assign busy            = (state_reg != ST_IDLE);
  assign led_start       = led_start_reg;
  assign led_color       = led_color_reg;
  assign led_start_index = led_index_reg;

endmodule

// File: tb/tb_led_strip_scheduler.sv
// Randomised frame-level bench for led_strip_scheduler: a transaction model predicts
// the round-robin winner, grant payload, and done/err timing of every frame.
module tb_led_strip_scheduler;

  localparam int N = 4;
  localparam int L = 8;
  localparam int T = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [24*N-1:0] req_color = '0;
  logic [7*N-1:0]  req_index = '0;
  logic          led_finish = 1'b0;
  logic [N-1:0]  done;
  logic          err;
  logic          timeout_sticky;
  logic          busy;
  logic          led_start;
  logic [23:0]   led_color;
  logic [6:0]    led_start_index;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  bit exp_sticky = 1'b0;

  led_strip_scheduler #(
    .N_REQ(N), .LATCH_CYCLES(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_color(req_color), .req_index(req_index),
    .done(done), .err(err), .timeout_sticky(timeout_sticky), .busy(busy),
    .led_start(led_start), .led_color(led_color), .led_start_index(led_start_index),
    .led_finish(led_finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_sticky"}, timeout_sticky, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, led_start, 0);
    check({tag, "_color"}, led_color, 0);
    check({tag, "_index"}, led_start_index, 0);
  endtask

  // One complete grant: k is the WAIT cycle of the finish edge (k > T means never).
  task automatic frame(input logic [N-1:0] mask, input int k, input bit stale,
                       input bit scramble, input int idle_pre);
    logic [23:0] col [N];
    logic [6:0]  ix  [N];
    int w, end_c, j;
    bit to;
    req = '0;
    for (int i = 0; i < idle_pre; i++) begin
      tick();
      check("idle_busy", busy, 0);
      check("idle_start", led_start, 0);
    end
    for (int i = 0; i < N; i++) begin
      col[i] = 24'($urandom());
      col[i][3:0] = 4'(i);
      ix[i] = 7'($urandom());
      req_color[24*i +: 24] = col[i];
      req_index[7*i +: 7] = ix[i];
    end
    req = mask;
    led_finish = stale;
    w = rr_pick(mask, exp_ptr);
    tick();
    $display("grant mask=%b owner=%0d k=%0d stale=%0d", mask, w, k, stale);
    check("start", led_start, 1);
    check("color", led_color, col[w]);
    check("index", led_start_index, ix[w]);
    check("busy_issue", busy, 1);
    if (scramble) begin
      req_color = {3{32'($urandom())}};
      req_index = 28'($urandom());
      req = 4'($urandom());
    end
    tick();
    check("start_off", led_start, 0);
    to = (k > T);
    end_c = to ? T : k;
    j = (k >= 2) ? 1 + int'($urandom_range(0, k - 2)) : 1;
    for (int c = 1; c <= end_c; c++) begin
      if (stale) led_finish = (c < j) ? 1'b1 : ((c < k) ? 1'b0 : 1'b1);
      else       led_finish = (c >= k);
      tick();
      if (c == end_c) begin
        check("done", done, 32'(1) << w);
        check("err", err, to);
        check("sticky", timeout_sticky, exp_sticky | to);
        check("color_hold", led_color, col[w]);
      end else begin
        check("done_early", done, 0);
        check("err_early", err, 0);
      end
    end
    exp_sticky |= to;
    for (int m = 1; m <= L; m++) begin
      tick();
      check("latch_busy", busy, (m < L));
      check("latch_done", done, 0);
      if (m == L) check("index_hold", led_start_index, ix[w]);
    end
    exp_ptr = (w + 1) % N;
  endtask

  initial begin
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    frame(4'b0001, 10, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) frame(4'b1111, 1 + int'($urandom_range(0, 11)), 1'b0, 1'b0, 0);
    frame(4'b1111, 7, 1'b1, 1'b0, 0);
    frame(4'b0101, T, 1'b0, 1'b0, 0);
    frame(4'b1010, T + 3, 1'b0, 1'b0, 0);
    frame(4'b0011, 3, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] mask;
      int k;
      bit stale;
      mask = 4'($urandom_range(1, 15));
      k = 1 + int'($urandom_range(0, T + 3));
      stale = (k >= 2) && ($urandom_range(0, 2) == 0);
      frame(mask, k, stale, 1'($urandom()), int'($urandom_range(0, 2)));
    end

    // Leave the pointer at 2, grant source 2, then reset in the middle of WAIT.
    frame(4'b0010, 4, 1'b0, 1'b0, 0);
    req = 4'b0100;
    led_finish = 1'b0;
    tick();
    check("pre_reset_start", led_start, 1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midreset");
    exp_ptr = 0;
    exp_sticky = 1'b0;
    frame(4'b0110, 5, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
